// File: rtl/ha_lane.sv
// ha_lane: single-bit combinational half-adder cell
module ha_lane (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/half_adder.sv
// half_adder: independent half-adder lanes with a registered result and a saturating carry-event counter
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  input  logic             en,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt,
  input  logic             cnt_clr
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_lane u_lane (
      .a(a[i]),
      .b(b[i]),
      .sum(sum[i]),
      .carry(carry[i])
    );
  end
  // capture the combinational result when enabled; valid only follows an enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end
  // count enabled cycles with any carry, clear wins over increment, stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      carry_cnt <= '0;
    else if (en && |carry && carry_cnt != CNT_MAX)
      carry_cnt <= carry_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed checks of a 1-lane/16-bit-counter instance and a 4-lane/2-bit-counter instance
module tb_half_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0, b = 1'b0, en = 1'b0, cnt_clr = 1'b0;
  logic        sum, carry, sum_q, carry_q, valid_q;
  logic [15:0] carry_cnt;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        en4 = 1'b0, clr4 = 1'b0;
  logic [3:0]  sum4, carry4, sum_q4, carry_q4;
  logic        valid_q4;
  logic [1:0]  cnt4;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum), .carry(carry), .en(en),
    .sum_q(sum_q), .carry_q(carry_q), .valid_q(valid_q), .carry_cnt(carry_cnt), .cnt_clr(cnt_clr)
  );

  half_adder #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .sum(sum4), .carry(carry4), .en(en4),
    .sum_q(sum_q4), .carry_q(carry_q4), .valid_q(valid_q4), .carry_cnt(cnt4), .cnt_clr(clr4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_sc [4];
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #1;
      chk($sformatf("comb_%0d", i), {30'd0, sum, carry}, {30'd0, exp_sc[i]});
      #9;
    end
    @(negedge clk);
    a = 1; b = 1; en = 1; rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_sum_q", sum_q, 0);
      chk("rst_carry_q", carry_q, 0);
      chk("rst_valid_q", valid_q, 0);
      chk("rst_cnt", carry_cnt, 0);
      chk("rst_comb", {sum, carry}, 32'b01);
    end
    chk("rst_cnt4", cnt4, 0);
    chk("rst_valid_q4", valid_q4, 0);
    rst = 0; a = 1; b = 0;
    @(negedge clk);
    chk("reg_sum_q", sum_q, 1);
    chk("reg_carry_q", carry_q, 0);
    chk("reg_valid_q", valid_q, 1);
    chk("reg_cnt_nocarry", carry_cnt, 0);
    en = 0; a = 0;
    @(negedge clk);
    chk("hold_valid_q", valid_q, 0);
    chk("hold_sum_q", sum_q, 1);
    en = 1; a = 1; b = 1;
    repeat (5) @(negedge clk);
    chk("cnt_5", carry_cnt, 5);
    chk("cnt_carry_q", carry_q, 1);
    cnt_clr = 1;
    @(negedge clk);
    chk("cnt_clr_prio", carry_cnt, 0);
    cnt_clr = 0;
    @(negedge clk);
    chk("cnt_after_clr", carry_cnt, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_over_en_cnt", carry_cnt, 0);
    chk("rst_over_en_valid", valid_q, 0);
    rst = 0; en = 0;
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    chk("ml_sum", sum4, 4'b0110);
    chk("ml_carry", carry4, 4'b1000);
    @(negedge clk);
    chk("ml_cnt_idle", cnt4, 0);
    en4 = 1;
    @(negedge clk);
    chk("ml_cnt_1", cnt4, 1);
    chk("ml_carry_q", carry_q4, 4'b1000);
    chk("ml_sum_q", sum_q4, 4'b0110);
    repeat (5) @(negedge clk);
    chk("sat_cnt", cnt4, 3);
    clr4 = 1;
    @(negedge clk);
    chk("sat_clr", cnt4, 0);
    clr4 = 0; en4 = 0;
    a4 = 4'b1x00; b4 = 4'b1010;
    #1;
    chk("x_sum", sum4, 4'b0x10);
    chk("x_carry", carry4, 4'b1000);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
